// File: rtl/logic_op_pipe.sv
// Elastic valid/ready pipeline computing a registered bitwise AND/OR/XOR/NAND of two operands.
// Optional transfer counter output done_cnt is enabled by defining LOGIC_OP_PIPE_CNT_EN.
module logic_op_pipe #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] q
`ifdef LOGIC_OP_PIPE_CNT_EN
    ,
    output logic [15:0]  done_cnt
`endif
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("logic_op_pipe: DEPTH must be at least 1");
    end
    if (W < 1) begin : g_bad_width
        $error("logic_op_pipe: W must be at least 1");
    end

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [DEPTH-1:0] rdy;
    logic [W-1:0]     d_q [DEPTH];
    logic [W-1:0]     d_d [DEPTH];
    logic [W-1:0]     f_res;

    always_comb begin
        f_res = a & b;
        case (op)
            2'b00:   f_res = a & b;
            2'b01:   f_res = a | b;
            2'b10:   f_res = a ^ b;
            default: f_res = ~(a & b);
        endcase
    end

    // A stage can take new data if it is empty or everything downstream of it moves.
    always_comb begin
        rdy = '0;
        rdy[DEPTH-1] = ~vld_q[DEPTH-1] | out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            rdy[i] = ~vld_q[i] | rdy[i+1];
        end
    end

    always_comb begin
        vld_d = vld_q;
        d_d   = d_q;
        if (rdy[0]) begin
            vld_d[0] = in_valid;
            if (in_valid) begin
                d_d[0] = f_res;
            end
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (rdy[i]) begin
                vld_d[i] = vld_q[i-1];
                if (vld_q[i-1]) begin
                    d_d[i] = d_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= d_d[i];
            end
        end
    end

    assign in_ready  = rdy[0] & ~reset;
    assign out_valid = vld_q[DEPTH-1];
    assign q         = d_q[DEPTH-1];

`ifdef LOGIC_OP_PIPE_CNT_EN
    logic [15:0] done_cnt_q;
    logic [15:0] done_cnt_d;

    // Free-running count of consumer transfers; wraps naturally at 16 bits.
    always_comb begin
        done_cnt_d = done_cnt_q;
        if (vld_q[DEPTH-1] && out_ready) begin
            done_cnt_d = done_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_cnt_q <= '0;
        end else begin
            done_cnt_q <= done_cnt_d;
        end
    end

    assign done_cnt = done_cnt_q;
`endif

endmodule
